shift_tx_feeder: RTL and testbench
==================================

// Module: shift_tx_feeder
// PURPOSE
//  Upstream stage of the UART shift transmitter. Buffers bytes from the host logic in a small FIFO
//  and wraps each byte into a UART frame {stop=1, data, start=0}. Hands frames one at a time to the
//  transmitter with a single-cycle send_en, then waits for frame_sent. A timeout guard, an
//  inter-frame gap and overflow/timeout error pulses complete the block.
// PARAMETERS
//  FRAME_WIDTH     10  bits per frame; must equal DATA_WIDTH+2
//  DATA_WIDTH      8   payload bits per frame
//  FIFO_DEPTH      8   byte FIFO entries; power of 2, >=2
//  GAP_CYCLES      2   idle baud_clk cycles after each frame before the next REQ; 0 = none
//  TIMEOUT_CYCLES  64  max WAIT_DONE cycles without frame_sent before abandoning the frame
// PORTS
//  baud_clk      in   1            single clock, transmitter bit clock
//  rst_n         in   1            asynchronous, active-low reset
//  wr_en         in   1            push wr_data into FIFO this cycle
//  wr_data       in   DATA_WIDTH   byte to send, LSB transmitted first
//  fifo_full     out  1            FIFO holds FIFO_DEPTH entries
//  fifo_empty    out  1            FIFO holds 0 entries
//  send_en       out  1            1-cycle request to transmitter, sampled in its IDLE
//  data_frame    out  FRAME_WIDTH  frame for transmitter, stable from LOAD until next LOAD
//  frame_sent    in   1            transmitter done pulse, high in its first IDLE cycle
//  busy          out  1            FSM not in IDLE or FIFO not empty
//  overflow_err  out  1            1-cycle pulse: wr_en while full, byte dropped
//  timeout_err   out  1            1-cycle pulse: frame abandoned after TIMEOUT_CYCLES
// BEHAVIOUR
//  Reset (async, rst_n=0): all outputs take their reset values immediately.
//   - send_en=0, data_frame=all ones (line-idle pattern), overflow_err=0, timeout_err=0.
//   - FIFO pointers/count=0, so fifo_empty=1, fifo_full=0, busy=0.
//   - State=IDLE; gap and timeout counters=0.
//   - Reset mid-frame discards the FIFO contents and the in-flight frame.
//  FIFO: count width clog2(FIFO_DEPTH)+1; pointers wrap modulo FIFO_DEPTH.
//   - Write when full is ignored and pulses overflow_err.
//   - Push and pop in the same edge are both performed, count unchanged; when full the pop frees space.
//   - Pop happens only in LOAD.
//  All outputs are registered. The FSM advances one state per baud_clk edge:
//   - IDLE: if !fifo_empty -> LOAD.
//   - LOAD: pop head; data_frame <= {1'b1, head, 1'b0}; -> REQ.
//   - REQ: send_en=1 for exactly this one cycle; timeout counter cleared; -> WAIT_DONE.
//   - WAIT_DONE: send_en=0; counter +1 per cycle.
//     - frame_sent=1 -> GAP.
//     - Else if counter==TIMEOUT_CYCLES-1 -> timeout_err=1 for one cycle, -> GAP.
//     - frame_sent wins over timeout on the same edge.
//   - GAP: counter counts GAP_CYCLES cycles, then -> IDLE. With GAP_CYCLES=0, WAIT_DONE goes directly to IDLE.
//  frame_sent outside WAIT_DONE is ignored and never advances the FSM.
//  Latency: a write into an empty FIFO with the FSM in IDLE at edge N gives LOAD at N+1 and send_en high from N+2 to N+3.
//  send_en is never high for 2 consecutive cycles. The transmitter is only requested after it reported done or timed out.
//  busy = (state!=IDLE) | !fifo_empty.
// TESTING
//  1. rst_n=0 mid-WAIT_DONE -> same cycle: send_en=0, data_frame=10'h3FF, fifo_empty=1, busy=0.
//     After release, no send_en until a new write.
//  2. Write 8'h47 at edge N, transmitter model answers -> data_frame=10'h28E at N+2, send_en high N+2..N+3 only.
//     Frame-sent response: frame_sent 10 cycles later; next REQ no earlier than 2 cycles after GAP entry.
//  3. 9 writes back-to-back while transmitter stalled -> fifo_full after the 8th, overflow_err pulse on the 9th.
//     The 8 stored bytes then go out in write order.
//  4. frame_sent held 0 -> timeout_err pulses after 64 WAIT_DONE cycles, then the next queued byte is requested normally.
//  5. Full FIFO with push and LOAD-pop on the same edge -> count stays 8, no overflow_err, pushed byte sent last.
//  6. Spurious frame_sent pulse in IDLE and in GAP -> no state change and no send_en.

Source files
------------

// File: rtl/shift_tx_feeder.sv
// shift_tx_feeder: byte FIFO plus frame sequencer ahead of the UART shift transmitter.
// Each byte becomes {stop=1, data, start=0} and is handed over with a one-cycle send_en.
// The block then waits for frame_sent, a timeout, or both, and leaves an idle gap
// before the next request.
module shift_tx_feeder #(
  parameter int FRAME_WIDTH    = 10,
  parameter int DATA_WIDTH     = 8,
  parameter int FIFO_DEPTH     = 8,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                   baud_clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [DATA_WIDTH-1:0]  wr_data,
  output logic                   fifo_full,
  output logic                   fifo_empty,
  output logic                   send_en,
  output logic [FRAME_WIDTH-1:0] data_frame,
  input  logic                   frame_sent,
  output logic                   busy,
  output logic                   overflow_err,
  output logic                   timeout_err
);

  localparam int AW      = $clog2(FIFO_DEPTH);
  localparam int CNT_MAX = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);

  localparam logic [AW:0]   DEPTH_C = (AW+1)'(FIFO_DEPTH);
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST = CW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {IDLE, LOAD, REQ, WAIT_DONE, GAP} state_t;

  state_t                               state;
  logic [CW-1:0]                        cnt;
  logic [FIFO_DEPTH-1:0][DATA_WIDTH-1:0] fifo_mem;
  logic [AW-1:0]                        wr_ptr;
  logic [AW-1:0]                        rd_ptr;
  logic [AW:0]                          count;
  logic                                 push;
  logic                                 pop;

  // The only read of the FIFO is the LOAD state. A pop on the same edge frees a slot,
  // so a write into a full FIFO is still accepted when it coincides with LOAD.
  assign pop  = (state == LOAD);
  assign push = wr_en && (!fifo_full || pop);

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_empty = (count == '0);
  assign busy       = (state != IDLE) || !fifo_empty;

  // Storage array; its contents are only meaningful behind the pointers, so no reset.
  always_ff @(posedge baud_clk) begin
    if (push) fifo_mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy bookkeeping. A dropped write raises a one-cycle overflow pulse.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      overflow_err <= 1'b0;
    end else begin
      overflow_err <= wr_en && !push;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Frame sequencer. cnt is shared: it counts WAIT_DONE cycles, then GAP cycles.
  always_ff @(posedge baud_clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      send_en     <= 1'b0;
      data_frame  <= '1;
      timeout_err <= 1'b0;
    end else begin
      send_en     <= 1'b0;
      timeout_err <= 1'b0;
      case (state)
        IDLE: begin
          if (!fifo_empty) state <= LOAD;
        end
        LOAD: begin
          data_frame <= {1'b1, fifo_mem[rd_ptr], 1'b0};
          send_en    <= 1'b1;
          state      <= REQ;
        end
        REQ: begin
          cnt   <= '0;
          state <= WAIT_DONE;
        end
        WAIT_DONE: begin
          // A done pulse on the final cycle still counts as a normal completion.
          if (frame_sent) begin
            cnt   <= '0;
            state <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else if (cnt == TO_LAST) begin
            timeout_err <= 1'b1;
            cnt         <= '0;
            state       <= (GAP_CYCLES == 0) ? IDLE : GAP;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        GAP: begin
          if (cnt == GAP_LAST) begin
            cnt   <= '0;
            state <= IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_shift_tx_feeder.sv
// Directed bench for shift_tx_feeder. A queue-based model tracks the expected outputs every
// cycle. A transmitter responder answers send_en after a programmable latency, or never.
// Literal checks pin latency, gap spacing, timeout length and byte order.
module tb_shift_tx_feeder;

  localparam int DW = 8, FW = 10, DEPTH = 8, GAPC = 2, TMO = 64;
  localparam int S_IDLE = 0, S_LOAD = 1, S_REQ = 2, S_WAIT = 3, S_GAP = 4;

  logic          baud_clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          wr_en, frame_sent, spur, resp_pulse;
  logic [DW-1:0] wr_data;
  logic          fifo_full, fifo_empty, send_en, busy, overflow_err, timeout_err;
  logic [FW-1:0] data_frame;

  int n_tests = 0, n_fail = 0;

  shift_tx_feeder #(.FRAME_WIDTH(FW), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH),
                    .GAP_CYCLES(GAPC), .TIMEOUT_CYCLES(TMO)) dut (
    .baud_clk(baud_clk), .rst_n(rst_n), .wr_en(wr_en), .wr_data(wr_data),
    .fifo_full(fifo_full), .fifo_empty(fifo_empty), .send_en(send_en),
    .data_frame(data_frame), .frame_sent(frame_sent), .busy(busy),
    .overflow_err(overflow_err), .timeout_err(timeout_err));

  always #5 baud_clk = ~baud_clk;
  assign frame_sent = resp_pulse | spur;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DW-1:0] mq[$];
  int            m_st, tmo_left, gap_left;
  logic          m_send, m_ovf, m_tmo;
  logic [FW-1:0] m_frame;

  task automatic model_reset();
    mq.delete();
    m_st = S_IDLE; m_send = 0; m_ovf = 0; m_tmo = 0; m_frame = '1;
    tmo_left = 0; gap_left = 0;
  endtask

  task automatic finish_frame();
    if (GAPC == 0) m_st = S_IDLE;
    else begin m_st = S_GAP; gap_left = GAPC; end
  endtask

  task automatic model_step();
    int had;
    logic [DW-1:0] head;
    had = mq.size();
    m_send = 0; m_ovf = 0; m_tmo = 0;
    case (m_st)
      S_IDLE: if (had > 0) m_st = S_LOAD;
      S_LOAD: begin
        head = mq.pop_front();
        m_frame = {1'b1, head, 1'b0};
        m_send = 1; m_st = S_REQ;
      end
      S_REQ:  begin tmo_left = TMO; m_st = S_WAIT; end
      S_WAIT: begin
        tmo_left--;
        if (frame_sent) finish_frame();
        else if (tmo_left == 0) begin m_tmo = 1; finish_frame(); end
      end
      S_GAP:  begin gap_left--; if (gap_left == 0) m_st = S_IDLE; end
      default: m_st = S_IDLE;
    endcase
    // The pop above has already happened, so a full queue plus a pop has room again.
    if (wr_en) begin
      if (mq.size() < DEPTH) mq.push_back(wr_data);
      else m_ovf = 1;
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge baud_clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare the DUT against the model once per cycle, away from the active edge.
  initial begin
    forever begin
      @(negedge baud_clk);
      if ($time > 0) begin
        chk("send_en",      send_en,      m_send);
        chk("data_frame",   data_frame,   m_frame);
        chk("fifo_empty",   fifo_empty,   mq.size() == 0);
        chk("fifo_full",    fifo_full,    mq.size() == DEPTH);
        chk("busy",         busy,         (m_st != S_IDLE) || (mq.size() != 0));
        chk("overflow_err", overflow_err, m_ovf);
        chk("timeout_err",  timeout_err,  m_tmo);
      end
    end
  end

  // ---------------- transmitter responder ----------------
  int            resp_lat = 10;
  int            cd = 0, cyc = 0, n_send = 0;
  logic [FW-1:0] sent_q[$];
  int            send_cyc_q[$], fs_cyc_q[$], tmo_cyc_q[$];

  initial begin
    resp_pulse = 0;
    forever begin
      @(negedge baud_clk);
      cyc++;
      resp_pulse = 0;
      if (!rst_n) cd = 0;
      else begin
        if (cd > 0) begin
          cd--;
          if (cd == 0) begin resp_pulse = 1; fs_cyc_q.push_back(cyc); end
        end
        if (send_en) begin
          n_send++;
          sent_q.push_back(data_frame);
          send_cyc_q.push_back(cyc);
          if (resp_lat > 0) cd = resp_lat;
        end
        if (timeout_err) tmo_cyc_q.push_back(cyc);
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(negedge baud_clk);
  endtask

  task automatic write(input logic [DW-1:0] b);
    wr_data = b; wr_en = 1'b1;
    tick();
    wr_en = 1'b0;
  endtask

  task automatic wait_st(input int s, input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (m_st == s) begin ok = 1; break; end
      tick();
    end
    chk("wait_state_reached", ok, 1);
  endtask

  task automatic wait_idle(input int max);
    int ok;
    ok = 0;
    for (int i = 0; i < max; i++) begin
      if (m_st == S_IDLE && mq.size() == 0) begin ok = 1; break; end
      tick();
    end
    chk("wait_idle_reached", ok, 1);
    repeat (2) tick();
  endtask

  task automatic pulse_spur();
    spur = 1'b1; tick(); spur = 1'b0;
  endtask

  initial begin
    int base, n0, ok;
    wr_en = 0; wr_data = 0; spur = 0;
    #2 rst_n = 1'b0;
    #1;
    chk("rst_send_en",    send_en,    0);
    chk("rst_data_frame", data_frame, 10'h3FF);
    chk("rst_fifo_empty", fifo_empty, 1);
    chk("rst_fifo_full",  fifo_full,  0);
    chk("rst_busy",       busy,       0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // Single byte: latency and frame format.
    wr_data = 8'h47; wr_en = 1'b1;
    tick(); wr_en = 1'b0;
    chk("lat_c1_send_en", send_en, 0);
    tick();
    chk("lat_c2_send_en", send_en, 0);
    tick();
    chk("lat_c3_send_en", send_en, 1);
    chk("lat_c3_frame",   data_frame, 10'h28E);
    tick();
    chk("lat_c4_send_en", send_en, 0);
    wait_idle(60);

    // Two back-to-back bytes: next request five cycles after frame_sent.
    send_cyc_q.delete(); fs_cyc_q.delete();
    write(8'h01); write(8'h02);
    wait_idle(100);
    chk("gap_spacing", send_cyc_q[1] - fs_cyc_q[0], 5);

    // Reset while waiting for the transmitter.
    resp_lat = 0;
    write(8'h11); write(8'h22); write(8'h33);
    wait_st(S_WAIT, 20);
    repeat (3) tick();
    @(posedge baud_clk); #2 rst_n = 1'b0;
    #1;
    chk("midrst_send_en",    send_en,    0);
    chk("midrst_data_frame", data_frame, 10'h3FF);
    chk("midrst_fifo_empty", fifo_empty, 1);
    chk("midrst_busy",       busy,       0);
    tick(); rst_n = 1'b1;
    n0 = n_send;
    repeat (12) tick();
    chk("midrst_no_send", n_send, n0);

    // Timeout on a stalled transmitter, then the next byte is served normally.
    send_cyc_q.delete(); tmo_cyc_q.delete(); sent_q.delete();
    write(8'h5A); write(8'h6B);
    ok = 0;
    for (int i = 0; i < 100; i++) begin
      if (tmo_cyc_q.size() > 0) begin ok = 1; break; end
      tick();
    end
    chk("timeout_seen", ok, 1);
    resp_lat = 3;
    wait_idle(60);
    if (ok == 1) chk("timeout_len", tmo_cyc_q[0] - send_cyc_q[0], 65);
    chk("timeout_count", tmo_cyc_q.size(), 1);
    chk("after_tmo_frame", sent_q[sent_q.size()-1], 10'h2D6);

    // Fill while stalled: full after 8, overflow on the 9th, 8 bytes leave in order.
    resp_lat = 0;
    write(8'hEE);
    wait_st(S_WAIT, 10);
    for (int i = 0; i < 9; i++) begin
      write(8'h10 + 8'(i));
      if (i == 6) chk("fill_not_full_7", fifo_full, 0);
      if (i == 7) begin chk("fill_full_8", fifo_full, 1); chk("fill_no_ovf_8", overflow_err, 0); end
      if (i == 8) chk("fill_ovf_9", overflow_err, 1);
    end
    resp_lat = 3;
    base = sent_q.size();
    wait_idle(400);
    chk("fill_sent_count", sent_q.size() - base, 8);
    for (int i = 0; i < 8; i++)
      if (base + i < sent_q.size()) chk("fill_order", sent_q[base+i], {1'b1, 8'h10 + 8'(i), 1'b0});

    // Push into a full FIFO on the same edge as the LOAD pop.
    resp_lat = 0;
    write(8'hDD);
    wait_st(S_WAIT, 10);
    for (int i = 0; i < 8; i++) write(8'h30 + 8'(i));
    chk("pp_full_before", fifo_full, 1);
    resp_lat = 2;
    pulse_spur();
    wait_st(S_LOAD, 10);
    wr_data = 8'hA5; wr_en = 1'b1;
    tick(); wr_en = 1'b0;
    chk("pp_full_after", fifo_full, 1);
    chk("pp_no_ovf",     overflow_err, 0);
    base = sent_q.size();
    wait_idle(300);
    chk("pp_sent_count", sent_q.size() - base, 8);
    chk("pp_last_byte",  sent_q[sent_q.size()-1], 10'h34A);

    // Spurious frame_sent in IDLE and in GAP.
    n0 = n_send;
    pulse_spur();
    repeat (5) tick();
    chk("spur_idle_no_send", n_send, n0);
    chk("spur_idle_busy",    busy, 0);
    resp_lat = 3;
    write(8'h77);
    wait_st(S_GAP, 40);
    pulse_spur();
    wait_idle(50);
    chk("spur_gap_one_send", n_send, n0 + 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
